// File: rtl/aes_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aes_host_ctrl
//  Purpose  : Host-side sequencer for an AES core. It accepts one
//             encrypt/decrypt request at a time, pulses the core load
//             strobes and waits for done under a timeout. It then returns
//             the result or a timeout error. The last decrypt key is cached
//             so that repeated decrypts skip inverse key expansion.
//  Revision : 1.0  initial release
// ============================================================================
module aes_host_ctrl #(
  parameter int TIMEOUT  = 32,
  parameter int KEY_WAIT = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_mode,
  input  logic [127:0] req_key,
  input  logic [127:0] req_text,
  output logic         mode,
  output logic         ld,
  output logic         kld,
  output logic [127:0] key,
  output logic [127:0] text_in,
  input  logic         done,
  input  logic [127:0] text_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int KW = $clog2(KEY_WAIT + 1);
  // The counters are compared before they increment, so the last BUSY or
  // KWAIT cycle is the one whose count is one below the limit.
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [KW-1:0] WAIT_LAST = KW'(KEY_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KLD   = 3'd1,
    S_KWAIT = 3'd2,
    S_LOAD  = 3'd3,
    S_BUSY  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [KW-1:0]  wcnt;
  logic [127:0]   last_key;
  logic           key_vld;
  logic           accept;
  logic           key_hit;
  logic           busy_done;
  logic           busy_timeout;

  assign accept       = (state == S_IDLE) && req_valid;
  assign key_hit      = key_vld && (req_key == last_key);
  // When done and the timeout land on the same cycle, done wins.
  assign busy_done    = (state == S_BUSY) && done;
  assign busy_timeout = (state == S_BUSY) && !done && (cnt == CNT_LAST);

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = (req_mode && !key_hit) ? S_KLD : S_LOAD;
      S_KLD:   state_nxt = S_KWAIT;
      S_KWAIT: if (wcnt == WAIT_LAST) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_BUSY;
      S_BUSY:  if (done || (cnt == CNT_LAST)) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each is high exactly
  // during the single cycle spent in KLD or LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld  <= 1'b0;
      kld <= 1'b0;
    end else begin
      ld  <= (state_nxt == S_LOAD);
      kld <= (state_nxt == S_KLD);
    end
  end

  // Core-side operands, captured at accept and held until the next accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode    <= 1'b0;
      key     <= '0;
      text_in <= '0;
    end else if (accept) begin
      mode    <= req_mode;
      key     <= req_key;
      text_in <= req_text;
    end
  end

  // Decrypt key cache; a timeout invalidates it because the core state is unknown
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_key <= '0;
      key_vld  <= 1'b0;
    end else if (state == S_KLD) begin
      last_key <= key;
      key_vld  <= 1'b1;
    end else if (busy_timeout) begin
      key_vld  <= 1'b0;
    end
  end

  // Cycle counters, cleared whenever their state is not active
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      wcnt <= '0;
    end else begin
      cnt  <= (state == S_BUSY)  ? cnt + CW'(1)  : '0;
      wcnt <= (state == S_KWAIT) ? wcnt + KW'(1) : '0;
    end
  end

  // Response capture; held stable throughout RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (busy_done) begin
      rsp_data <= text_out;
      rsp_err  <= 1'b0;
    end else if (busy_timeout) begin
      rsp_data <= '0;
      rsp_err  <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_host_ctrl
//  Purpose  : Directed self-checking bench for aes_host_ctrl with a
//             latency-programmable AES core stub.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_host_ctrl;

  localparam int TIMEOUT  = 32;
  localparam int KEY_WAIT = 10;

  localparam logic [127:0] K1    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] STRAY = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [127:0] TIE   = 128'hcafef00dcafef00dcafef00dcafef00d;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_mode;
  logic [127:0] req_key, req_text;
  logic         mode, ld, kld;
  logic [127:0] key, text_in;
  logic         done;
  logic [127:0] text_out;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_err;

  logic         stub_done;
  logic [127:0] stub_text;
  logic         stray_done;
  int           stub_lat;
  logic [127:0] stub_data;
  int           rem;

  int n_checks = 0;
  int n_errors = 0;
  int ld_c, kld_c, ld_n, kld_n, both_n, rsp_c;

  assign done     = stub_done | stray_done;
  assign text_out = stray_done ? STRAY : stub_text;

  aes_host_ctrl #(.TIMEOUT(TIMEOUT), .KEY_WAIT(KEY_WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_key(req_key), .req_text(req_text),
    .mode(mode), .ld(ld), .kld(kld), .key(key), .text_in(text_in),
    .done(done), .text_out(text_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Core stub: done pulses in BUSY cycle stub_lat after ld (0 = never)
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stub_done <= 1'b0;
      stub_text <= '0;
      rem = 0;
    end else begin
      stub_done <= 1'b0;
      if (ld && stub_lat > 0) rem = stub_lat;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          stub_done <= 1'b1;
          stub_text <= stub_data;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns just after the accept edge
  task automatic start_req(input logic m, input logic [127:0] k, input logic [127:0] t);
    req_mode  = m;
    req_key   = k;
    req_text  = t;
    req_valid = 1'b1;
    chk_bit("req_ready_idle", req_ready, 1'b1);
    @(posedge clk);
  endtask

  // Samples cycles 1..bound after accept, stopping at the first rsp_valid
  task automatic watch(input int bound);
    ld_c = -1; kld_c = -1; ld_n = 0; kld_n = 0; both_n = 0; rsp_c = -1;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (ld && kld) both_n++;
      if (ld) begin
        ld_n++;
        if (ld_c < 0) ld_c = c;
      end
      if (kld) begin
        kld_n++;
        if (kld_c < 0) kld_c = c;
      end
      if (rsp_valid) begin
        rsp_c = c;
        break;
      end
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk_bit("idle_after_rsp", req_ready, 1'b1);
    chk_bit("rsp_valid_dropped", rsp_valid, 1'b0);
  endtask

  initial begin
    // Reset with random inputs
    rst        = 1'b0;
    req_valid  = 1'($urandom);
    req_mode   = 1'($urandom);
    req_key    = {$urandom, $urandom, $urandom, $urandom};
    req_text   = {$urandom, $urandom, $urandom, $urandom};
    rsp_ready  = 1'($urandom);
    stray_done = 1'($urandom);
    stub_lat   = 0;
    stub_data  = '0;
    repeat (3) @(negedge clk);
    chk_bit("rst_req_ready", req_ready, 1'b1);
    chk_bit("rst_rsp_valid", rsp_valid, 1'b0);
    chk_bit("rst_ld", ld, 1'b0);
    chk_bit("rst_kld", kld, 1'b0);
    chk_bit("rst_mode", mode, 1'b0);
    chk("rst_key", key, '0);
    chk("rst_text_in", text_in, '0);
    chk_bit("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_data", rsp_data, '0);
    req_valid  = 1'b0;
    rsp_ready  = 1'b0;
    stray_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Encrypt FIPS-197 C.1
    stub_lat = 5; stub_data = CT;
    start_req(1'b0, K1, PT);
    watch(100);
    chk_int("enc_ld_cycle", ld_c, 1);
    chk_int("enc_ld_count", ld_n, 1);
    chk_int("enc_kld_count", kld_n, 0);
    chk_int("enc_rsp_cycle", rsp_c, 7);
    chk("enc_rsp_data", rsp_data, CT);
    chk_bit("enc_rsp_err", rsp_err, 1'b0);
    chk_bit("enc_mode", mode, 1'b0);
    chk("enc_key", key, K1);
    chk("enc_text_in", text_in, PT);
    handshake();

    // Decrypt with a new key: kld, KEY_WAIT cycles, then ld
    stub_lat = 3; stub_data = PT;
    start_req(1'b1, K1, CT);
    watch(100);
    chk_int("dec1_kld_cycle", kld_c, 1);
    chk_int("dec1_kld_count", kld_n, 1);
    chk_int("dec1_ld_cycle", ld_c, KEY_WAIT + 2);
    chk_int("dec1_overlap", both_n, 0);
    chk_int("dec1_rsp_cycle", rsp_c, KEY_WAIT + 2 + 3 + 1);
    chk("dec1_rsp_data", rsp_data, PT);
    chk_bit("dec1_mode", mode, 1'b1);
    handshake();

    // Decrypt again under the cached key
    start_req(1'b1, K1, CT);
    watch(100);
    chk_int("dec2_kld_count", kld_n, 0);
    chk_int("dec2_ld_cycle", ld_c, 1);
    chk_int("dec2_rsp_cycle", rsp_c, 5);
    chk("dec2_rsp_data", rsp_data, PT);
    handshake();

    // Timeout: core never answers
    stub_lat = 0;
    start_req(1'b1, K1, CT);
    watch(100);
    chk_int("to_ld_cycle", ld_c, 1);
    chk_int("to_rsp_cycle", rsp_c, 1 + TIMEOUT + 1);
    chk_bit("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_data", rsp_data, '0);
    handshake();

    // Same key after a timeout must reload the key
    stub_lat = 3; stub_data = PT;
    start_req(1'b1, K1, CT);
    watch(100);
    chk_int("post_to_kld_cycle", kld_c, 1);
    chk_int("post_to_ld_cycle", ld_c, KEY_WAIT + 2);
    chk("post_to_rsp_data", rsp_data, PT);
    handshake();

    // Backpressure with a stray done while in RESP
    stub_lat = 4; stub_data = CT;
    start_req(1'b0, K1, PT);
    watch(100);
    chk_int("bp_rsp_cycle", rsp_c, 6);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_bit("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_data", rsp_data, CT);
      chk_bit("bp_rsp_err", rsp_err, 1'b0);
      chk_bit("bp_req_ready", req_ready, 1'b0);
      stray_done = (i == 5);
    end
    stray_done = 1'b0;
    handshake();

    // done coincides with the final timeout cycle
    stub_lat = TIMEOUT; stub_data = TIE;
    start_req(1'b0, K1, PT);
    watch(100);
    chk_int("tie_rsp_cycle", rsp_c, 1 + TIMEOUT + 1);
    chk_bit("tie_rsp_err", rsp_err, 1'b0);
    chk("tie_rsp_data", rsp_data, TIE);
    handshake();

    // Reset during BUSY of a cached-key decrypt
    stub_lat = 0;
    start_req(1'b1, K1, CT);
    watch(6);
    chk_int("rb_ld_cycle", ld_c, 1);
    chk_int("rb_kld_count", kld_n, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rb_key_in_reset", key, '0);
    rst = 1'b1;
    watch(40);
    chk_int("rb_no_rsp", rsp_c, -1);
    stub_lat = 3; stub_data = PT;
    start_req(1'b1, K1, CT);
    watch(100);
    chk_int("rb_next_kld_cycle", kld_c, 1);
    chk("rb_next_rsp_data", rsp_data, PT);
    handshake();

    // Reset during KWAIT of a new-key decrypt
    stub_lat = 0;
    start_req(1'b1, K2, CT);
    watch(4);
    chk_int("rk_kld_cycle", kld_c, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    watch(40);
    chk_int("rk_no_rsp", rsp_c, -1);
    stub_lat = 3; stub_data = PT;
    start_req(1'b1, K2, CT);
    watch(100);
    chk_int("rk_next_kld_cycle", kld_c, 1);
    chk_int("rk_next_ld_cycle", ld_c, KEY_WAIT + 2);
    chk("rk_next_rsp_data", rsp_data, PT);
    handshake();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
